// File: rtl/way_data_array.sv
// way_data_array: multi-way cache line store with byte-enabled writes and a registered
// write-first read port. Define DATA_ARRAY_INIT_EN to add the post-reset clear sweep.
module way_data_array #(
    parameter int NUM_SETS   = 16,
    parameter int SET_IDX    = 4,
    parameter int NUM_WAYS   = 2,
    parameter int WAY_IDX    = 1,
    parameter int LINE_BYTES = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rd_req,
    input  logic [SET_IDX-1:0]      rd_set,
    input  logic [WAY_IDX-1:0]      rd_way,
    output logic                    rd_valid,
    output logic [8*LINE_BYTES-1:0] rd_data,
    input  logic [LINE_BYTES-1:0]   wr_be,
    input  logic [SET_IDX-1:0]      wr_set,
    input  logic [WAY_IDX-1:0]      wr_way,
    input  logic [8*LINE_BYTES-1:0] wr_data,
    output logic                    init_busy
);
    localparam int LW = 8 * LINE_BYTES;

    logic [LW-1:0] mem [NUM_SETS][NUM_WAYS];
    logic          accept;
    logic          wr_en;
    logic          rd_en;
    logic          hit;
    logic [LW-1:0] fwd;

`ifdef DATA_ARRAY_INIT_EN
    typedef enum logic {INIT, READY} state_t;
    state_t             state;
    state_t             state_n;
    logic [SET_IDX-1:0] cnt;
    logic               busy;

    // leave the sweep after the cycle that clears the last set
    always_comb state_n = (state == INIT && cnt == SET_IDX'(NUM_SETS - 1)) ? READY : state;

    // state, sweep counter and registered busy flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= INIT;
            cnt   <= '0;
            busy  <= 1'b1;
        end else begin
            state <= state_n;
            cnt   <= (state == INIT) ? cnt + 1'b1 : cnt;
            busy  <= state_n == INIT;
        end
    end

    assign init_busy = busy;
    assign accept    = state == READY;
`else
    assign init_busy = rst;
    assign accept    = 1'b1;
`endif

    assign wr_en = accept && |wr_be;
    assign rd_en = accept && rd_req;
    assign hit   = wr_en && wr_set == rd_set && wr_way == rd_way;

    // write-first read: enabled bytes of a same-line write override the stored line
    always_comb begin
        fwd = mem[rd_set][rd_way];
        for (int i = 0; i < LINE_BYTES; i++)
            if (hit && wr_be[i]) fwd[8*i +: 8] = wr_data[8*i +: 8];
    end

    // storage: the sweep zeroes a whole set, otherwise a byte-masked line write
    always_ff @(posedge clk) begin
        if (!rst) begin
`ifdef DATA_ARRAY_INIT_EN
            if (state == INIT)
                for (int w = 0; w < NUM_WAYS; w++) mem[cnt][WAY_IDX'(w)] <= '0;
`endif
            if (wr_en)
                for (int i = 0; i < LINE_BYTES; i++)
                    if (wr_be[i]) mem[wr_set][wr_way][8*i +: 8] <= wr_data[8*i +: 8];
        end
    end

    // read result register; rd_data holds its last value when no read is issued
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) rd_data <= fwd;
        end
    end
endmodule

// File: tb/tb_way_data_array.sv
// tb_way_data_array: table-driven check of way_data_array plus hand-written reset/sweep sequences
module tb_way_data_array;
    localparam logic [31:0] ALL = 32'hFFFF_FFFF;
`ifdef DATA_ARRAY_INIT_EN
    localparam int INIT_CYC = 16;
`else
    localparam int INIT_CYC = 0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         rd_req;
    logic [3:0]   rd_set;
    logic         rd_way;
    logic         rd_valid;
    logic [255:0] rd_data;
    logic [31:0]  wr_be;
    logic [3:0]   wr_set;
    logic         wr_way;
    logic [255:0] wr_data;
    logic         init_busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0]  be;
        logic [3:0]   ws;
        logic         ww;
        logic [255:0] wd;
        logic         rq;
        logic [3:0]   rs;
        logic         rw;
        logic         ev;
        logic [255:0] ed;
    } vec_t;

    vec_t tv[22];

    way_data_array dut (
        .clk(clk), .rst(rst), .rd_req(rd_req), .rd_set(rd_set), .rd_way(rd_way),
        .rd_valid(rd_valid), .rd_data(rd_data), .wr_be(wr_be), .wr_set(wr_set),
        .wr_way(wr_way), .wr_data(wr_data), .init_busy(init_busy)
    );

    always #5 clk = ~clk;

    function automatic logic [255:0] fill(input logic [7:0] b);
        return {32{b}};
    endfunction

    function automatic logic [255:0] mrg(input logic [255:0] a, input logic [255:0] b, input logic [255:0] m);
        return (a & ~m) | (b & m);
    endfunction

    function automatic vec_t mk(input logic [31:0] be, input logic [3:0] ws, input logic ww,
                                input logic [255:0] wd, input logic rq, input logic [3:0] rs,
                                input logic rw, input logic ev, input logic [255:0] ed);
        vec_t v;
        v.be = be; v.ws = ws; v.ww = ww; v.wd = wd;
        v.rq = rq; v.rs = rs; v.rw = rw; v.ev = ev; v.ed = ed;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rd_req = 1'b0; rd_set = '0; rd_way = '0;
        wr_be = '0; wr_set = '0; wr_way = '0; wr_data = '0;
    endtask

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_init(input bit inject);
        int n = 0;
        while (init_busy && n < 64) begin
            idle();
            if (inject && n == 2) begin
                wr_be = ALL; wr_set = 4'd3; wr_way = 1'b1; wr_data = fill(8'hAA);
                rd_req = 1'b1; rd_set = 4'd3; rd_way = 1'b1;
            end
            step();
            n++;
            chk("init_rd_valid", {255'd0, rd_valid}, 256'd0);
        end
        idle();
        chk("init_busy_cycles", 256'(n), 256'(INIT_CYC));
    endtask

    task automatic rd(input logic [3:0] s, input logic w, input logic [255:0] exp, input string nm);
        idle();
        rd_req = 1'b1; rd_set = s; rd_way = w;
        step();
        idle();
        chk({nm, "_valid"}, {255'd0, rd_valid}, 256'd1);
        chk({nm, "_data"}, rd_data, exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [255:0] m = (256'hFF << 248) | 256'hFF;
        tv[0]  = mk(ALL,          4'd5,  1'b0, fill(8'h11), 1'b0, 4'd0,  1'b0, 1'b0, 256'd0);
        tv[1]  = mk(32'h0000_000F, 4'd5, 1'b0, fill(8'hFF), 1'b1, 4'd5,  1'b0, 1'b1, fill(8'h11) | 256'hFFFF_FFFF);
        tv[2]  = mk(32'd0,        4'd0,  1'b0, 256'd0,      1'b1, 4'd5,  1'b0, 1'b1, fill(8'h11) | 256'hFFFF_FFFF);
        tv[3]  = mk(32'd0,        4'd0,  1'b0, 256'd0,      1'b1, 4'd5,  1'b1, 1'b1, 256'd0);
        tv[4]  = mk(ALL,          4'd7,  1'b1, fill(8'h22), 1'b1, 4'd7,  1'b1, 1'b1, fill(8'h22));
        tv[5]  = mk(32'h8000_0001, 4'd7, 1'b1, fill(8'hCC), 1'b1, 4'd7,  1'b1, 1'b1, mrg(fill(8'h22), fill(8'hCC), m));
        tv[6]  = mk(32'h8000_0001, 4'd7, 1'b1, fill(8'hDD), 1'b1, 4'd7,  1'b0, 1'b1, 256'd0);
        tv[7]  = mk(32'd0,        4'd0,  1'b0, 256'd0,      1'b1, 4'd7,  1'b1, 1'b1, mrg(fill(8'h22), fill(8'hDD), m));
        tv[8]  = mk(ALL,          4'd6,  1'b1, fill(8'hEE), 1'b1, 4'd7,  1'b1, 1'b1, mrg(fill(8'h22), fill(8'hDD), m));
        tv[9]  = mk(ALL,          4'd0,  1'b0, fill(8'h01), 1'b0, 4'd7,  1'b1, 1'b0, mrg(fill(8'h22), fill(8'hDD), m));
        tv[10] = mk(ALL,          4'd1,  1'b0, fill(8'h02), 1'b0, 4'd0,  1'b0, 1'b0, mrg(fill(8'h22), fill(8'hDD), m));
        tv[11] = mk(ALL,          4'd2,  1'b0, fill(8'h03), 1'b0, 4'd0,  1'b0, 1'b0, mrg(fill(8'h22), fill(8'hDD), m));
        tv[12] = mk(ALL,          4'd3,  1'b0, fill(8'h04), 1'b0, 4'd0,  1'b0, 1'b0, mrg(fill(8'h22), fill(8'hDD), m));
        tv[13] = mk(32'd0,        4'd0,  1'b0, 256'd0,      1'b1, 4'd0,  1'b0, 1'b1, fill(8'h01));
        tv[14] = mk(32'd0,        4'd0,  1'b0, 256'd0,      1'b1, 4'd1,  1'b0, 1'b1, fill(8'h02));
        tv[15] = mk(32'd0,        4'd0,  1'b0, 256'd0,      1'b1, 4'd2,  1'b0, 1'b1, fill(8'h03));
        tv[16] = mk(32'd0,        4'd0,  1'b0, 256'd0,      1'b1, 4'd3,  1'b0, 1'b1, fill(8'h04));
        tv[17] = mk(32'd0,        4'd0,  1'b0, 256'd0,      1'b0, 4'd0,  1'b0, 1'b0, fill(8'h04));
        tv[18] = mk(32'd0,        4'd0,  1'b0, 256'd0,      1'b0, 4'd0,  1'b0, 1'b0, fill(8'h04));
        tv[19] = mk(ALL,          4'd15, 1'b1, fill(8'h5A), 1'b1, 4'd0,  1'b1, 1'b1, 256'd0);
        tv[20] = mk(32'd0,        4'd0,  1'b0, 256'd0,      1'b1, 4'd15, 1'b1, 1'b1, fill(8'h5A));
        tv[21] = mk(32'd0,        4'd15, 1'b1, fill(8'hFF), 1'b1, 4'd15, 1'b1, 1'b1, fill(8'h5A));

        idle();
        rst = 1'b1;
        step();
        step();
        chk("rst_rd_valid", {255'd0, rd_valid}, 256'd0);
        chk("rst_rd_data", rd_data, 256'd0);
        chk("rst_init_busy", {255'd0, init_busy}, 256'd1);
        rst = 1'b0;
        #1;
        wait_init(1'b1);
        rd(4'd3, 1'b1, 256'd0, "init_drop_s3w1");

`ifdef DATA_ARRAY_INIT_EN
        for (int s = 0; s < 16; s++)
            for (int w = 0; w < 2; w++) begin
                idle();
                wr_be = ALL; wr_set = 4'(s); wr_way = 1'(w); wr_data = fill(8'hA5);
                step();
            end
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        wait_init(1'b0);
`endif
        for (int s = 0; s < 16; s++)
            for (int w = 0; w < 2; w++)
                rd(4'(s), 1'(w), 256'd0, $sformatf("clear_s%0dw%0d", s, w));

        for (int i = 0; i < 22; i++) begin
            rd_req = tv[i].rq; rd_set = tv[i].rs; rd_way = tv[i].rw;
            wr_be = tv[i].be; wr_set = tv[i].ws; wr_way = tv[i].ww; wr_data = tv[i].wd;
            step();
            chk($sformatf("vec%0d_valid", i), {255'd0, rd_valid}, {255'd0, tv[i].ev});
            chk($sformatf("vec%0d_data", i), rd_data, tv[i].ed);
        end

        idle();
        rd_req = 1'b1; rd_set = 4'd15; rd_way = 1'b1;
        wr_be = ALL; wr_set = 4'd4; wr_way = 1'b0; wr_data = fill(8'h77);
        rst = 1'b1;
        step();
        chk("midrst_rd_valid", {255'd0, rd_valid}, 256'd0);
        chk("midrst_rd_data", rd_data, 256'd0);
        chk("midrst_init_busy", {255'd0, init_busy}, 256'd1);
        idle();
        rst = 1'b0;
        #1;
        wait_init(1'b0);
        rd(4'd4, 1'b0, 256'd0, "midrst_nowrite_s4w0");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
